// File: rtl/switch_cond_pkg.sv
// Shared constants and state encoding for the switch input-conditioning stage.
package switch_cond_pkg;

  localparam int unsigned SW_WIDTH         = 8;
  localparam int unsigned SYNC_STAGES_DEF  = 2;
  localparam int unsigned DEBOUNCE_CNT_DEF = 1000000;
  localparam int unsigned SIM_DEBOUNCE_CNT = 4;

  // Bit positions of the gate-block operands on the debounced bus
  localparam int unsigned SW_A      = 0;
  localparam int unsigned SW_B      = 1;
  localparam int unsigned SW_A1_LSB = 2;
  localparam int unsigned SW_B1_LSB = 5;

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_COUNTING = 1'b1
  } db_state_e;

  function automatic int unsigned cnt_width(input int unsigned cnt_max);
    return $clog2(cnt_max + 1);
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// Single-bit synchroniser chain followed by a hold-time debounce FSM.
module debounce_bit
  import switch_cond_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned CNT_MAX     = DEBOUNCE_CNT_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int unsigned CW = cnt_width(CNT_MAX);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic                   mismatch;
  logic [CW-1:0]          cnt;
  db_state_e              state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end
  end

  assign sync     = sync_q[SYNC_STAGES-1];
  assign mismatch = (sync != level);

  // The counter holds how many consecutive edges have seen a mismatch; the
  // new level is taken on the CNT_MAX-th such edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_STABLE;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      case (state)
        ST_STABLE: begin
          cnt <= '0;
          if (mismatch) begin
            if (CNT_MAX == 1) begin
              level <= sync;
              rise  <= sync;
              fall  <= ~sync;
            end else begin
              state <= ST_COUNTING;
              cnt   <= CW'(1);
            end
          end
        end
        ST_COUNTING: begin
          if (!mismatch) begin
            state <= ST_STABLE;
            cnt   <= '0;
          end else if (cnt == CW'(CNT_MAX - 1)) begin
            level <= sync;
            rise  <= sync;
            fall  <= ~sync;
            state <= ST_STABLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= ST_STABLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/switch_debounce_sync.sv
// Synchronises and debounces the slide-switch bus feeding the AND-gate block.
module switch_debounce_sync
  import switch_cond_pkg::*;
#(
  parameter int unsigned WIDTH       = SW_WIDTH,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned CNT_MAX     = DEBOUNCE_CNT_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_db,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             any_change
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .SYNC_STAGES(SYNC_STAGES),
      .CNT_MAX    (CNT_MAX)
    ) u_bit (
      .clk    (clk),
      .reset_n(reset_n),
      .din    (sw_in[i]),
      .level  (sw_db[i]),
      .rise   (sw_rise[i]),
      .fall   (sw_fall[i])
    );
  end

  // Combinational OR of registered pulses, same cycle as the pulses
  assign any_change = |{sw_rise, sw_fall};

endmodule

// File: tb/tb_switch_debounce_sync.sv
// Self-checking bench: scheduled expectations popped whenever the DUT pulses.
module tb_switch_debounce_sync;
  import switch_cond_pkg::*;

  localparam int unsigned W   = SW_WIDTH;
  localparam int unsigned SS  = SYNC_STAGES_DEF;
  localparam int unsigned CM  = SIM_DEBOUNCE_CNT;
  localparam int          LAT = int'(SS) - 1 + int'(CM);

  logic         clk     = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] sw_in   = '1;
  logic [W-1:0] sw_db;
  logic [W-1:0] sw_rise;
  logic [W-1:0] sw_fall;
  logic         any_change;

  switch_debounce_sync #(
    .WIDTH      (W),
    .SYNC_STAGES(SS),
    .CNT_MAX    (CM)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .sw_in     (sw_in),
    .sw_db     (sw_db),
    .sw_rise   (sw_rise),
    .sw_fall   (sw_fall),
    .any_change(any_change)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] db;
    logic [7:0] rise;
    logic [7:0] fall;
  } exp_t;

  typedef struct {
    logic [7:0] sw;
    logic [7:0] db;
    logic [7:0] rise;
    logic [7:0] fall;
  } vec_t;

  exp_t sbq[$];
  vec_t vecs[6];
  int   edge_n = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) edge_n <= edge_n + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at edge %0d: got %h, required %h", name, edge_n, act, req);
    end
  endfunction

  // Expected result lands LAT edges after the first edge that samples the stimulus
  task automatic expect_event(input logic [7:0] db, input logic [7:0] rise, input logic [7:0] fall);
    exp_t e;
    e.cyc  = edge_n + 1 + LAT;
    e.db   = db;
    e.rise = rise;
    e.fall = fall;
    sbq.push_back(e);
  endtask

  task automatic drain(input string name);
    check(name, 32'(sbq.size()), 32'd0);
    sbq.delete();
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (any_change !== 1'b0) begin
      if (sbq.size() == 0) begin
        check("spurious_pulse", {8'h00, sw_rise, sw_fall, 7'b0, any_change}, 32'h0);
      end else begin
        e = sbq.pop_front();
        check("ev_cycle", 32'(edge_n), 32'(e.cyc));
        check("ev_db", 32'(sw_db), 32'(e.db));
        check("ev_rise", 32'(sw_rise), 32'(e.rise));
        check("ev_fall", 32'(sw_fall), 32'(e.fall));
        check("ev_excl", 32'(sw_rise & sw_fall), 32'h0);
      end
    end
  end

  initial begin
    vecs[0] = '{sw: 8'h00, db: 8'h00, rise: 8'h00, fall: 8'hFF};
    vecs[1] = '{sw: 8'h01, db: 8'h01, rise: 8'h01, fall: 8'h00};
    vecs[2] = '{sw: 8'h00, db: 8'h00, rise: 8'h00, fall: 8'h01};
    vecs[3] = '{sw: 8'h6F, db: 8'h6F, rise: 8'h6F, fall: 8'h00};
    vecs[4] = '{sw: 8'h26, db: 8'h26, rise: 8'h00, fall: 8'h49};
    vecs[5] = '{sw: 8'h00, db: 8'h00, rise: 8'h00, fall: 8'h26};

    // Reset held with all switches on
    reset_n = 1'b0;
    sw_in   = 8'hFF;
    repeat (20) begin
      @(negedge clk);
      check("rst_db", 32'(sw_db), 32'h0);
      check("rst_pulse", {8'h00, sw_rise, sw_fall, 7'b0, any_change}, 32'h0);
    end
    reset_n = 1'b1;
    expect_event(8'hFF, 8'hFF, 8'h00);
    repeat (12) @(negedge clk);
    check("rel_db", 32'(sw_db), 32'hFF);
    drain("rel_drain");

    // Table of clean steps, including multi-bit rise and fall
    for (int i = 0; i < 6; i++) begin
      sw_in = vecs[i].sw;
      expect_event(vecs[i].db, vecs[i].rise, vecs[i].fall);
      repeat (12) @(negedge clk);
      check("vec_db", 32'(sw_db), 32'(vecs[i].db));
      drain("vec_drain");
    end

    // Three-cycle glitch on bit 1 must be ignored
    sw_in = 8'h02;
    repeat (3) @(negedge clk);
    sw_in = 8'h00;
    repeat (12) @(negedge clk);
    check("glitch_db", 32'(sw_db), 32'h0);
    drain("glitch_drain");
    // A following real step on bit 1 takes the full latency
    sw_in = 8'h02;
    expect_event(8'h02, 8'h02, 8'h00);
    repeat (12) @(negedge clk);
    check("glitch_step_db", 32'(sw_db), 32'h02);
    sw_in = 8'h00;
    expect_event(8'h00, 8'h00, 8'h02);
    repeat (12) @(negedge clk);
    drain("glitch_step_drain");

    // Bounce on bit 2, then settle high
    for (int p = 0; p < 6; p++) begin
      sw_in = (p % 2 == 0) ? 8'h04 : 8'h00;
      repeat (2) @(negedge clk);
    end
    sw_in = 8'h04;
    expect_event(8'h04, 8'h04, 8'h00);
    repeat (12) @(negedge clk);
    check("bounce_db", 32'(sw_db), 32'h04);
    sw_in = 8'h00;
    expect_event(8'h00, 8'h00, 8'h04);
    repeat (12) @(negedge clk);
    drain("bounce_drain");

    // Reset pulse one edge before bit 7 would be accepted
    sw_in = 8'h80;
    repeat (5) begin
      @(negedge clk);
      check("midrst_pre_db", 32'(sw_db), 32'h0);
    end
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_db", 32'(sw_db), 32'h0);
    check("midrst_pulse", {8'h00, sw_rise, sw_fall, 7'b0, any_change}, 32'h0);
    reset_n = 1'b1;
    expect_event(8'h80, 8'h80, 8'h00);
    repeat (12) @(negedge clk);
    check("midrst_post_db", 32'(sw_db), 32'h80);
    sw_in = 8'h00;
    expect_event(8'h00, 8'h00, 8'h80);
    repeat (12) @(negedge clk);
    check("final_db", 32'(sw_db), 32'h0);
    drain("final_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
